bcd_entry_to_binary: RTL and testbench
======================================

# bcd_entry_to_binary

Sequential decimal-to-binary converter: accepts decimal digits one per handshake, most significant first (keypad/switch entry), and on commit converts the collected digits to an unsigned binary value by iterative multiply-by-10-and-add. It is the input-side counterpart of the three-digit binary-to-decimal display path. Its binary result feeds the datapath, and can be looped back to the display for echo.

## Interface
Parameters:
- NUM_DIGITS, 3, maximum decimal digits held per number
- OUT_W, 8, width of binary result

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- digit_in  input  4  BCD digit, valid 0–9
- digit_valid  input  1  digit_in offered this cycle
- digit_ready  output  1  block can accept a digit this cycle
- commit  input  1  start conversion of the held digits
- clear  input  1  discard digits, abort conversion, zero result
- digit_count  output  $clog2(NUM_DIGITS+1)  digits currently held
- value  output  OUT_W  last converted result, held
- value_valid  output  1  one-cycle pulse when value updates
- overflow  output  1  last result exceeded 2^OUT_W−1, held with value
- digit_err  output  1  one-cycle pulse when a digit >9 was offered

Clocking and reset: one clock; reset is synchronous and active-high.

## Operation
- States: ENTRY, CONV. Reset → ENTRY, digit register all zero, digit_count=0, value=0, overflow=0, value_valid=0, digit_err=0. digit_ready=1 after reset.
- digit_ready = (state==ENTRY) && (digit_count < NUM_DIGITS).
- Accept: digit_valid && digit_ready && digit_in≤9 → shift digit into LSD slot, older digits move up, digit_count+1.
- digit_valid && digit_ready && digit_in>9 → digit dropped, count unchanged, digit_err pulses.
- digit_valid when not ready (full or CONV) → ignored, no digit_err.
- commit in ENTRY → CONV, acc=0, idx=MSD slot. A commit in CONV is ignored.
- Unused upper slots hold 0, so CONV always runs NUM_DIGITS steps: acc = acc*10 + slot[idx].
- Final step:
  - If the result is ≤2^OUT_W−1: value=result, overflow=0.
  - Otherwise: value=all ones (saturate), overflow=1.
  - In both cases value_valid pulses, the digit register and count clear, and state → ENTRY.
- Width rule: acc is ACC_W = ceil(log2(10^NUM_DIGITS)) bits (10 for defaults). ×10 is implemented as (acc<<3)+(acc<<1). There are no multipliers or dividers.
- Priority: reset > clear > commit > digit accept.
- clear (any state): digits, count, value and overflow → 0, state → ENTRY, no value_valid.
- commit with digit_count=0 → converts to 0, value_valid pulses, overflow=0.
- commit and an accepted digit in the same cycle: the digit is captured and included in the conversion.
- value and overflow hold until the next completed conversion or clear.

## Timing
- All outputs are registered except digit_ready, which is decoded from state and count.
- Digit accepted at edge E → digit_count updated after E; digit_err asserted for the cycle after E.
- commit sampled at edge E0 → CONV for edges E1..E(NUM_DIGITS). value, overflow and value_valid are loaded at edge E(NUM_DIGITS), so value_valid is high for exactly the cycle after it.
- Latency commit→value_valid: NUM_DIGITS cycles (3).
- digit_ready low from E0 through E(NUM_DIGITS) and high the cycle after. A new digit can be accepted in the same cycle value_valid is high.
- Back-to-back: a commit in the value_valid cycle starts a new conversion, giving 0 with an empty register.
- reset or clear mid-CONV: takes effect at that edge, and no value_valid is produced for the aborted conversion.

## Structure
- Package bcd_entry_pkg:
  - state enum {ENTRY, CONV}
  - function acc_width(NUM_DIGITS)
  - constant BCD_MAX=9
- Sub-module bcd_mac_step: combinational ACC_W-bit acc*10+digit via shift-add, instantiated once and reused each CONV step.
- Top: FSM, digit shift register (NUM_DIGITS×4), step index counter, acc register, saturation compare.

## Test plan
- Enter 2,5,5 then commit → value_valid exactly 3 cycles after the commit edge, value=255, overflow=0, digit_count back to 0.
- Enter 2,5,6, commit → value=255, overflow=1; then enter 4,2, commit → value=42, overflow=0.
- Offer digit 12 → digit_err pulses one cycle, digit_count unchanged; then 7 and commit → value=7.
- Enter 1,2,3, then offer 9 while full → digit_ready=0, digit ignored, no digit_err; commit → 123.
- Enter 9,9, commit, assert clear during the 2nd CONV cycle → no value_valid, value=0, digit_ready=1 next cycle.
- Commit with no digits → value=0, value_valid pulse. In the same cycle, commit and accept digit 8 with an empty register → value=8.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// +--------------------------------------------------------------------------+
// | bcd_entry_pkg: shared types and constants for bcd_entry_to_binary         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package bcd_entry_pkg;

  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    CONV  = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Bits needed to hold any value of num_digits decimal digits.
  function automatic int acc_width(input int num_digits);
    longint p;
    p = 1;
    for (int i = 0; i < num_digits; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mac_step.sv
// +--------------------------------------------------------------------------+
// | bcd_mac_step: combinational acc*10 + digit using shift-add only           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_mac_step #(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] result
);

  assign result = (acc << 3) + (acc << 1) + ACC_W'(digit);

endmodule

`default_nettype wire

// File: rtl/bcd_entry_to_binary.sv
// +--------------------------------------------------------------------------+
// | bcd_entry_to_binary: serial decimal digit entry, converted to binary      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_entry_to_binary
  import bcd_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        digit_in,
  input  logic                              digit_valid,
  output logic                              digit_ready,
  input  logic                              commit,
  input  logic                              clear,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic [OUT_W-1:0]                  value,
  output logic                              value_valid,
  output logic                              overflow,
  output logic                              digit_err
);

  localparam int ACC_W = acc_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic [IDX_W-1:0] MSD_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e             state, state_next;
  logic [3:0]         slots [NUM_DIGITS];
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   mac_result;
  logic [CMP_W-1:0]   result_ext;
  logic [CMP_W-1:0]   limit;
  logic               over;
  logic               offered;
  logic               accept;
  logic               bad_digit;
  logic               last_step;

  assign digit_ready = (state == ENTRY) && (digit_count < CNT_W'(NUM_DIGITS));
  assign offered     = digit_valid && digit_ready && !clear;
  assign accept      = offered && (digit_in <= BCD_MAX);
  assign bad_digit   = offered && (digit_in > BCD_MAX);
  assign last_step   = (state == CONV) && (idx == '0);

  bcd_mac_step #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc    (acc),
    .digit  (slots[idx]),
    .result (mac_result)
  );

  assign result_ext = CMP_W'(mac_result);
  assign limit      = CMP_W'({OUT_W{1'b1}});
  assign over       = result_ext > limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ENTRY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ENTRY:   if (commit)    state_next = CONV;
      CONV:    if (last_step) state_next = ENTRY;
      default:                state_next = ENTRY;
    endcase
    if (clear) begin
      state_next = ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slots[i] <= '0;
      end
      digit_count <= '0;
      idx         <= '0;
      acc         <= '0;
      value       <= '0;
      overflow    <= 1'b0;
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
      if (clear) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          slots[i] <= '0;
        end
        digit_count <= '0;
        value       <= '0;
        overflow    <= 1'b0;
      end else if (state == CONV) begin
        acc <= mac_result;
        idx <= idx - 1'b1;
        if (last_step) begin
          value       <= over ? {OUT_W{1'b1}} : OUT_W'(result_ext);
          overflow    <= over;
          value_valid <= 1'b1;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            slots[i] <= '0;
          end
          digit_count <= '0;
        end
      end else begin
        // A digit accepted alongside commit lands in the LSD before CONV reads it.
        if (accept) begin
          slots[0] <= digit_in;
          for (int i = 1; i < NUM_DIGITS; i++) begin
            slots[i] <= slots[i-1];
          end
          digit_count <= digit_count + 1'b1;
        end
        if (bad_digit) begin
          digit_err <= 1'b1;
        end
        if (commit) begin
          acc <= '0;
          idx <= MSD_IDX;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_entry_to_binary.sv
// +--------------------------------------------------------------------------+
// | tb_bcd_entry_to_binary: directed scoreboard bench for bcd_entry_to_binary |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bcd_entry_to_binary;

  logic       clk;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       commit;
  logic       clear;
  logic [1:0] digit_count;
  logic [7:0] value;
  logic       value_valid;
  logic       overflow;
  logic       digit_err;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    logic [7:0] v;
    logic       ov;
    int         due;
  } exp_t;

  exp_t sb[$];

  bcd_entry_to_binary #(
    .NUM_DIGITS (3),
    .OUT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .commit      (commit),
    .clear       (clear),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .overflow    (overflow),
    .digit_err   (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every value_valid pops the oldest expected conversion.
  always @(negedge clk) begin
    if (!reset && value_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_value_valid", 32'(value_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("value", 32'(value), 32'(e.v));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [7:0] v, input logic ov);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    sb.push_back('{v: v, ov: ov, due: cyc + 3});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      tick();
    end
    if (sb.size() > 0) begin
      chk("conversion_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    reset       = 1'b1;
    digit_in    = '0;
    digit_valid = 1'b0;
    commit      = 1'b0;
    clear       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_value_valid", 32'(value_valid), 32'd0);
    chk("rst_digit_err", 32'(digit_err), 32'd0);
    chk("rst_ready", 32'(digit_ready), 32'd1);

    // 255 fits exactly
    put(4'd2); put(4'd5); put(4'd5);
    chk("count_full", 32'(digit_count), 32'd3);
    do_commit(8'd255, 1'b0);
    chk("ready_in_conv", 32'(digit_ready), 32'd0);
    wait_done();
    chk("count_after_conv", 32'(digit_count), 32'd0);
    chk("ready_after_conv", 32'(digit_ready), 32'd1);

    // 256 saturates, then a short number
    put(4'd2); put(4'd5); put(4'd6);
    do_commit(8'd255, 1'b1);
    wait_done();
    chk("overflow_held", 32'(overflow), 32'd1);
    put(4'd4); put(4'd2);
    chk("count_two", 32'(digit_count), 32'd2);
    do_commit(8'd42, 1'b0);
    wait_done();

    // Invalid digit
    put(4'd12);
    chk("digit_err_pulse", 32'(digit_err), 32'd1);
    chk("count_after_bad", 32'(digit_count), 32'd0);
    tick();
    chk("digit_err_clears", 32'(digit_err), 32'd0);
    put(4'd7);
    do_commit(8'd7, 1'b0);
    wait_done();

    // Digit offered while full is ignored silently
    put(4'd1); put(4'd2); put(4'd3);
    chk("ready_when_full", 32'(digit_ready), 32'd0);
    put(4'd9);
    chk("no_err_when_full", 32'(digit_err), 32'd0);
    chk("count_when_full", 32'(digit_count), 32'd3);
    do_commit(8'd123, 1'b0);
    wait_done();
    chk("value_held", 32'(value), 32'd123);

    // Clear during the second CONV cycle aborts the conversion
    put(4'd9); put(4'd9);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_value", 32'(value), 32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    chk("clear_ready", 32'(digit_ready), 32'd1);
    chk("clear_count", 32'(digit_count), 32'd0);
    repeat (5) tick();

    // Empty commit, then commit together with a digit
    do_commit(8'd0, 1'b0);
    wait_done();
    digit_in    = 4'd8;
    digit_valid = 1'b1;
    do_commit(8'd8, 1'b0);
    digit_valid = 1'b0;
    wait_done();
    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
